// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the RV32M/RV64M iterative multiply/divide unit:
// instruction field codes, funct3 operation codes, FSM states and helpers.
package ex_muldiv_pkg;

   localparam logic [6:0]  INST_TYPE_R   = 7'b0110011;
   localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;
   localparam logic [63:0] ZERO_WORD     = 64'h0;
   localparam logic        HOLD_ENABLE   = 1'b1;
   localparam logic        HOLD_DISABLE  = 1'b0;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   // Decode helper for the execute stage: R-type with the M-extension funct7.
   function automatic logic is_muldiv_inst(input logic [6:0] opcode, input logic [6:0] funct7);
      return (opcode == INST_TYPE_R) && (funct7 == FUNCT7_MULDIV);
   endfunction

   // rs1 is interpreted as signed for MUL, MULH, MULHSU, DIV and REM.
   function automatic logic op1_is_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   // rs2 is interpreted as signed for MUL, MULH, DIV and REM (not MULHSU).
   function automatic logic op2_is_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface ex_muldiv_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  start_i;
   logic [2:0]            op_i;
   logic [XLEN-1:0]       op1_i;
   logic [XLEN-1:0]       op2_i;
   logic [REG_ADDR_W-1:0] reg_w_addr_i;
   logic                  flush_i;
   logic                  hold_flag_o;
   logic                  busy_o;
   logic                  valid_o;
   logic [XLEN-1:0]       result_o;
   logic                  reg_w_ena_o;
   logic [REG_ADDR_W-1:0] reg_w_addr_o;

   modport master (
      output start_i, op_i, op1_i, op2_i, reg_w_addr_i, flush_i,
      input  hold_flag_o, busy_o, valid_o, result_o, reg_w_ena_o, reg_w_addr_o
   );

   modport slave (
      input  start_i, op_i, op1_i, op2_i, reg_w_addr_i, flush_i,
      output hold_flag_o, busy_o, valid_o, result_o, reg_w_ena_o, reg_w_addr_o
   );
endinterface

// File: rtl/ex_muldiv_sign.sv
// Sign handling for the mul/div unit: operand magnitudes and sign flags at
// issue time, plus a conditional two's-complement negate for the final value.
module muldiv_sign
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]        op_i,
   input  logic [XLEN-1:0]   op1_i,
   input  logic [XLEN-1:0]   op2_i,
   input  logic [2*XLEN-1:0] val_i,
   input  logic              neg_i,
   output logic [XLEN-1:0]   abs1_o,
   output logic [XLEN-1:0]   abs2_o,
   output logic              sign1_o,
   output logic              sign2_o,
   output logic [2*XLEN-1:0] val_o
);

   // Magnitudes of the operands (only negative signed operands are flipped)
   // and the conditional negate used on the finished product/quotient/remainder.
   always_comb begin
      sign1_o = op1_is_signed(op_i) & op1_i[XLEN-1];
      sign2_o = op2_is_signed(op_i) & op2_i[XLEN-1];
      abs1_o  = sign1_o ? (~op1_i + 1'b1) : op1_i;
      abs2_o  = sign2_o ? (~op2_i + 1'b1) : op2_i;
      val_o   = neg_i ? (~val_i + 1'b1) : val_i;
   end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit. Shift-add multiply and restoring
// divide on unsigned magnitudes, one bit per cycle, sign fixed up at the end.
// Divide-by-zero and signed overflow are answered directly without iterating.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic     clk,
   input  logic     rst,
   ex_muldiv_if.slave bus
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   muldiv_state_e         state_q, state_d;
   muldiv_op_e            op_q, op_d;
   logic [REG_ADDR_W-1:0] addr_q, addr_d;
   logic [XLEN-1:0]       a_q, a_d;          // multiplicand or divisor magnitude
   logic [2*XLEN-1:0]     acc_q, acc_d;      // {hi, lo} product or {rem, quot}
   logic                  neg_q, neg_d;      // negate the final value
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [XLEN-1:0]       result_q, result_d;

   logic [XLEN-1:0]       abs1, abs2;
   logic                  sign1, sign2;
   logic [2*XLEN-1:0]     fin_val, fin_signed;
   logic [XLEN-1:0]       result_fin;
   logic [XLEN:0]         mul_sum, div_shift, div_trial;
   logic [2*XLEN-1:0]     acc_step;
   logic                  div_by_zero, div_ovf, accept;
   logic [XLEN-1:0]       special_res;

   muldiv_sign #(.XLEN(XLEN)) u_sign (
      .op_i    (bus.op_i),
      .op1_i   (bus.op1_i),
      .op2_i   (bus.op2_i),
      .val_i   (fin_val),
      .neg_i   (neg_q),
      .abs1_o  (abs1),
      .abs2_o  (abs2),
      .sign1_o (sign1),
      .sign2_o (sign2),
      .val_o   (fin_signed)
   );

   // One iteration step and the sign-corrected result of the final step.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? a_q : {XLEN{1'b0}})};
      div_shift = acc_q[2*XLEN-1:XLEN-1];
      div_trial = div_shift - {1'b0, a_q};
      if (op_q[2]) begin
         // A clear top bit means no borrow, so the trial remainder is kept.
         if (!div_trial[XLEN])
            acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
         else
            acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
      end

      if (op_q[2] && op_q[1])
         fin_val = {{XLEN{1'b0}}, acc_step[2*XLEN-1:XLEN]};
      else if (op_q[2])
         fin_val = {{XLEN{1'b0}}, acc_step[XLEN-1:0]};
      else
         fin_val = acc_step;

      if (op_q[2] || (op_q == OP_MUL))
         result_fin = fin_signed[XLEN-1:0];
      else
         result_fin = fin_signed[2*XLEN-1:XLEN];
   end

   // Issue-time detection of the cases answered without iterating.
   always_comb begin
      accept      = bus.start_i && !bus.flush_i;
      div_by_zero = bus.op_i[2] && (bus.op2_i == {XLEN{1'b0}});
      div_ovf     = bus.op_i[2] && !bus.op_i[0] &&
                    (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (bus.op2_i == {XLEN{1'b1}});
      if (div_by_zero)
         special_res = bus.op_i[1] ? bus.op1_i : {XLEN{1'b1}};
      else
         special_res = bus.op_i[1] ? {XLEN{1'b0}} : bus.op1_i;
   end

   // Next-state logic: accept, iterate, present, with flush taking priority.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      a_d      = a_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d   = muldiv_op_e'(bus.op_i);
               addr_d = bus.reg_w_addr_i;
               a_d    = bus.op_i[2] ? abs2 : abs1;
               acc_d  = {{XLEN{1'b0}}, (bus.op_i[2] ? abs1 : abs2)};
               neg_d  = (bus.op_i[2] && bus.op_i[1]) ? sign1 : (sign1 ^ sign2);
               cnt_d  = '0;
               if (div_by_zero || div_ovf) begin
                  result_d = special_res;
                  state_d  = ST_DONE;
               end else begin
                  state_d  = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN - 1)) begin
               result_d = result_fin;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (bus.flush_i)
         state_d = ST_IDLE;
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MUL;
         addr_q   <= '0;
         a_q      <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         a_q      <= a_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   // Outputs; a flush in the DONE cycle suppresses the result.
   always_comb begin
      bus.busy_o       = (state_q != ST_IDLE);
      bus.valid_o      = (state_q == ST_DONE) && !bus.flush_i;
      bus.reg_w_ena_o  = bus.valid_o;
      bus.result_o     = bus.valid_o ? result_q : ZERO_WORD[XLEN-1:0];
      bus.reg_w_addr_o = bus.busy_o ? addr_q : {REG_ADDR_W{1'b0}};
      bus.hold_flag_o  = (((state_q == ST_IDLE) && accept) || (state_q == ST_CALC)) ?
                         HOLD_ENABLE : HOLD_DISABLE;
   end

endmodule
